// File: rtl/dbus_store_buffer_pkg.sv
// Shared types for the data-bus store buffer: bus request/response
// structs, the buffered store entry and the controller state encoding.
package sb_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STRB_W   = DATA_W / 8;
    localparam int SIZE_W   = 3;

    // Default number of store entries; must be a power of two, >= 2.
    localparam int SB_DEPTH = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [SIZE_W-1:0] msize_t;
    typedef logic [STRB_W-1:0] strobe_t;
    typedef logic [DATA_W-1:0] word_t;

    // Bus request: strobe != 0 marks a write, strobe == 0 a read.
    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    // One buffered store (also reused to hold the captured load).
    typedef struct packed {
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } sb_entry_t;

    typedef enum logic [2:0] {
        SB_IDLE       = 3'd0,
        SB_DRAIN_ADDR = 3'd1,
        SB_DRAIN_DATA = 3'd2,
        SB_READ_ADDR  = 3'd3,
        SB_READ_DATA  = 3'd4
    } sb_state_t;

endpackage

// File: rtl/dbus_store_buffer_fifo.sv
// sb_fifo: DEPTH-entry synchronous FIFO of buffered stores. Pointers wrap
// naturally because DEPTH is a power of two; the count is one bit wider so
// that count == DEPTH unambiguously means full.
module sb_fifo
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  sb_entry_t              wdata_i,
    output sb_entry_t              head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer and occupancy values; simultaneous push and pop keep the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dbus_store_buffer.sv
// dbus_store_buffer: posted-write buffer between the core data port and
// the downstream bus. Stores are acknowledged immediately and drained in
// FIFO order; a load waits until every buffered store has completed and
// then passes through, so memory ordering stays strict.
//
// Handshake: a request is presented with valid=1 and held stable until
// addr_ok is seen in the same cycle; the transfer completes on data_ok,
// which may coincide with addr_ok. mreq is built only from registers.
module dbus_store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  dbus_req_t              creq,
    output dbus_resp_t             cresp,
    output dbus_req_t              mreq,
    input  dbus_resp_t             mresp,
    output logic                   sb_empty,
    output logic [$clog2(DEPTH):0] sb_count
);

    sb_state_t              state_q, state_d;
    sb_entry_t              rd_q, rd_d;
    sb_entry_t              creq_entry, head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full, fifo_empty;
    logic                   wr_req, rd_req, wr_accept, rd_start;
    logic                   in_read, in_drain, drain_done, rd_done;

    assign creq_entry = '{addr: creq.addr, size: creq.size,
                          strobe: creq.strobe, data: creq.data};

    assign wr_req   = creq.valid && (|creq.strobe);
    assign rd_req   = creq.valid && (creq.strobe == '0);
    assign in_read  = (state_q == SB_READ_ADDR) || (state_q == SB_READ_DATA);
    assign in_drain = (state_q == SB_DRAIN_ADDR) || (state_q == SB_DRAIN_DATA);

    // A full buffer refuses the write even if a pop retires an entry this cycle.
    assign wr_accept = wr_req && !fifo_full && !in_read;
    // A load leaves IDLE only once nothing is buffered (drain has priority).
    assign rd_start  = (state_q == SB_IDLE) && fifo_empty && rd_req;

    assign drain_done = ((state_q == SB_DRAIN_ADDR) && mresp.addr_ok && mresp.data_ok) ||
                        ((state_q == SB_DRAIN_DATA) && mresp.data_ok);
    assign rd_done    = ((state_q == SB_READ_ADDR) && mresp.addr_ok && mresp.data_ok) ||
                        ((state_q == SB_READ_DATA) && mresp.data_ok);

    assign rd_d = rd_start ? creq_entry : rd_q;

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_accept),
        .pop_i   (drain_done),
        .wdata_i (creq_entry),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= SB_IDLE;
        else       state_q <= state_d;
    end

    // Captured load request, held for the whole read transaction.
    always_ff @(posedge clk) begin
        if (reset) rd_q <= '0;
        else       rd_q <= rd_d;
    end

    // Next-state logic. A store pushed in IDLE starts its drain at the
    // same edge so the downstream request appears in the following cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_IDLE: begin
                if (!fifo_empty || wr_accept) state_d = SB_DRAIN_ADDR;
                else if (rd_start)            state_d = SB_READ_ADDR;
            end
            SB_DRAIN_ADDR: begin
                if (mresp.addr_ok) state_d = mresp.data_ok ? SB_IDLE : SB_DRAIN_DATA;
            end
            SB_DRAIN_DATA: begin
                if (mresp.data_ok) state_d = SB_IDLE;
            end
            SB_READ_ADDR: begin
                if (mresp.addr_ok) state_d = mresp.data_ok ? SB_IDLE : SB_READ_DATA;
            end
            SB_READ_DATA: begin
                if (mresp.data_ok) state_d = SB_IDLE;
            end
            default: state_d = SB_IDLE;
        endcase
    end

    // Output muxing: downstream request from registers, core response and status.
    always_comb begin
        mreq  = '0;
        cresp = '0;
        if (in_read) begin
            mreq.addr   = rd_q.addr;
            mreq.size   = rd_q.size;
            mreq.strobe = rd_q.strobe;
            mreq.data   = rd_q.data;
        end else begin
            mreq.addr   = head.addr;
            mreq.size   = head.size;
            mreq.strobe = head.strobe;
            mreq.data   = head.data;
        end
        mreq.valid = (state_q == SB_DRAIN_ADDR) || (state_q == SB_READ_ADDR);

        if (wr_accept) begin
            cresp.addr_ok = 1'b1;
            cresp.data_ok = 1'b1;
        end else if (rd_done) begin
            cresp.addr_ok = 1'b1;
            cresp.data_ok = 1'b1;
            cresp.data    = mresp.data;
        end

        sb_empty = fifo_empty && !in_drain;
    end

    assign sb_count = fifo_count;

endmodule

// File: tb/tb_dbus_store_buffer.sv
// Bench for dbus_store_buffer: a latency-configurable memory responder,
// a store scoreboard (ordered queue of accepted stores plus occupancy)
// and scenario tasks called in sequence.
module tb_dbus_store_buffer;
    import sb_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 71;

    logic                   clk;
    logic                   reset;
    dbus_req_t              creq, mreq;
    dbus_resp_t             cresp, mresp;
    logic                   sb_empty;
    logic [$clog2(DEPTH):0] sb_count;

    dbus_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .creq     (creq),
        .cresp    (cresp),
        .mreq     (mreq),
        .mresp    (mresp),
        .sb_empty (sb_empty),
        .sb_count (sb_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted stores in order, and their occupancy.
    logic [W-1:0] exp_q[$];
    int           model_cnt = 0;
    bit           store_inflight = 0;
    bit           read_inflight = 0;
    logic [31:0]  read_addr_exp = '0;
    int           mem_wr_seen = 0;
    int           mem_rd_seen = 0;

    // Memory responder configuration and state.
    bit mem_stall = 0, mem_armed = 0, mem_phase = 0, force_resp = 0;
    int mem_acnt = 0, mem_dcnt = 0;
    int lat_a_min = 0, lat_a_max = 0, lat_d_min = 0, lat_d_max = 0;

    // Values sampled mid-cycle by tick().
    dbus_req_t              s_mreq;
    dbus_resp_t             s_cresp, s_mresp;
    logic                   s_empty;
    logic [$clog2(DEPTH):0] s_count;

    // One clock cycle: drive mresp at negedge, sample and score, pass posedge.
    task automatic tick();
        dbus_resp_t r;
        bit         exp_acc, rd_done;
        int         d;
        @(negedge clk);
        r = '0;
        if (reset) begin
            mem_armed = 0;
            mem_phase = 0;
        end else if (force_resp) begin
            r.addr_ok = 1'b1;
            r.data_ok = 1'b1;
            r.data    = $urandom;
        end else if (mem_phase) begin
            if (mem_dcnt == 0) begin
                r.data_ok = 1'b1;
                r.data    = $urandom;
                mem_phase = 0;
            end else begin
                mem_dcnt--;
            end
        end else if (mreq.valid && !mem_stall) begin
            if (!mem_armed) begin
                mem_armed = 1;
                mem_acnt  = $urandom_range(lat_a_max, lat_a_min);
            end
            if (mem_acnt == 0) begin
                mem_armed = 0;
                r.addr_ok = 1'b1;
                d = $urandom_range(lat_d_max, lat_d_min);
                if (d == 0) begin
                    r.data_ok = 1'b1;
                    r.data    = $urandom;
                end else begin
                    mem_phase = 1;
                    mem_dcnt  = d - 1;
                end
            end else begin
                mem_acnt--;
            end
        end
        mresp = r;
        #1;
        s_mreq  = mreq;
        s_cresp = cresp;
        s_mresp = mresp;
        s_empty = sb_empty;
        s_count = sb_count;
        if (reset) begin
            exp_q.delete();
            model_cnt      = 0;
            store_inflight = 0;
            read_inflight  = 0;
        end else begin
            checks++;
            if (int'(sb_count) != model_cnt) begin
                errors++;
                $display("FAIL sb_count: got %0d expected %0d at %0t", sb_count, model_cnt, $time);
            end
            checks++;
            if (sb_empty !== (model_cnt == 0)) begin
                errors++;
                $display("FAIL sb_empty: got %0b expected %0b at %0t", sb_empty, model_cnt == 0, $time);
            end
            exp_acc = creq.valid && (creq.strobe != 0) && (model_cnt < DEPTH);
            if (mreq.valid && mreq.strobe == 0) begin
                checks++;
                if (model_cnt != 0 || store_inflight) begin
                    errors++;
                    $display("FAIL read_order: load issued with %0d stores pending at %0t", model_cnt, $time);
                end
            end
            if (mreq.valid && mresp.addr_ok) begin
                if (mreq.strobe != 0) begin
                    checks++;
                    if (exp_q.size() == 0 ||
                        {mreq.addr, mreq.size, mreq.strobe, mreq.data} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL drain_entry: got addr %08h data %08h expected %018h at %0t",
                                 mreq.addr, mreq.data, (exp_q.size() > 0) ? exp_q[0] : '0, $time);
                    end
                    if (exp_q.size() > 0) store_inflight = 1;
                    mem_wr_seen++;
                end else begin
                    checks++;
                    if (mreq.addr !== read_addr_exp) begin
                        errors++;
                        $display("FAIL read_addr: got %08h expected %08h", mreq.addr, read_addr_exp);
                    end
                    read_inflight = 1;
                    mem_rd_seen++;
                end
            end
            rd_done = 0;
            if (mresp.data_ok) begin
                if (store_inflight) begin
                    store_inflight = 0;
                    void'(exp_q.pop_front());
                    model_cnt--;
                end else if (read_inflight) begin
                    read_inflight = 0;
                    rd_done = 1;
                end
            end
            checks++;
            if (cresp.addr_ok !== (exp_acc || rd_done) || cresp.data_ok !== (exp_acc || rd_done)) begin
                errors++;
                $display("FAIL cresp_ok: got %0b/%0b expected %0b at %0t", cresp.addr_ok,
                         cresp.data_ok, exp_acc || rd_done, $time);
            end
            if (rd_done) begin
                checks++;
                if (cresp.data !== mresp.data) begin
                    errors++;
                    $display("FAIL read_data: got %08h expected %08h", cresp.data, mresp.data);
                end
            end
            if (exp_acc) begin
                exp_q.push_back({creq.addr, creq.size, creq.strobe, creq.data});
                model_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Core-side store: hold the request until acknowledged.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] sz);
        bit ok = 0;
        int n  = 0;
        creq        = '0;
        creq.valid  = 1'b1;
        creq.addr   = a;
        creq.data   = d;
        creq.strobe = s;
        creq.size   = sz;
        while (!ok && n < 100) begin
            tick();
            ok = s_cresp.addr_ok;
            n++;
        end
        creq = '0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL write_timeout: addr %08h not accepted in %0d cycles", a, n);
        end
    endtask

    // Core-side load: hold the request until the response returns.
    task automatic do_read(input logic [31:0] a);
        bit ok = 0;
        int n  = 0;
        creq          = '0;
        creq.valid    = 1'b1;
        creq.addr     = a;
        creq.size     = 3'd2;
        read_addr_exp = a;
        while (!ok && n < 300) begin
            tick();
            ok = s_cresp.addr_ok;
            n++;
        end
        creq = '0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL read_timeout: addr %08h no response in %0d cycles", a, n);
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        tick();
        while (!s_empty && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (!s_empty) begin
            errors++;
            $display("FAIL drain_timeout: sb_empty still 0 with count %0d", s_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        creq  = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (s_mreq.valid !== 1'b0 || s_empty !== 1'b1 || s_count !== '0 || s_cresp !== '0) begin
                errors++;
                $display("FAIL reset_idle: valid %0b empty %0b count %0d expected 0 1 0",
                         s_mreq.valid, s_empty, s_count);
            end
        end
    endtask

    task automatic test_single_write();
        lat_a_min = 2; lat_a_max = 2; lat_d_min = 0; lat_d_max = 0;
        creq        = '0;
        creq.valid  = 1'b1;
        creq.addr   = 32'h8000_0010;
        creq.data   = 32'hDEAD_BEEF;
        creq.strobe = 4'hF;
        creq.size   = 3'd2;
        tick();
        checks++;
        if (s_cresp.addr_ok !== 1'b1 || s_cresp.data_ok !== 1'b1) begin
            errors++;
            $display("FAIL wr_ack: got %0b/%0b expected 1/1", s_cresp.addr_ok, s_cresp.data_ok);
        end
        creq = '0;
        tick();
        checks++;
        if (s_mreq.valid !== 1'b1 || s_mreq.addr !== 32'h8000_0010 ||
            s_mreq.data !== 32'hDEAD_BEEF || s_mreq.strobe !== 4'hF) begin
            errors++;
            $display("FAIL mreq_entry: got v%0b %08h %08h %h expected v1 80000010 deadbeef f",
                     s_mreq.valid, s_mreq.addr, s_mreq.data, s_mreq.strobe);
        end
        tick();
        tick();
        checks++;
        if (s_mreq.valid !== 1'b1 || s_empty !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold: valid %0b empty %0b expected 1 0", s_mreq.valid, s_empty);
        end
        tick();
        checks++;
        if (s_empty !== 1'b1 || s_count !== '0) begin
            errors++;
            $display("FAIL empty_after_pop: empty %0b count %0d expected 1 0", s_empty, s_count);
        end
    endtask

    task automatic test_full();
        int seen0 = mem_wr_seen;
        int n     = 0;
        bit ok    = 0;
        mem_stall = 1;
        lat_a_min = 0; lat_a_max = 0; lat_d_min = 1; lat_d_max = 1;
        for (int i = 0; i < 5; i++) begin
            creq        = '0;
            creq.valid  = 1'b1;
            creq.addr   = 32'h0000_1000 + 32'(i * 4);
            creq.data   = $urandom;
            creq.strobe = 4'hF;
            creq.size   = 3'd2;
            tick();
            checks++;
            if (s_cresp.addr_ok !== (i < 4)) begin
                errors++;
                $display("FAIL fill_accept: write %0d got %0b expected %0b", i, s_cresp.addr_ok, i < 4);
            end
        end
        mem_stall = 0;
        while (!ok && n < 50) begin
            tick();
            ok = s_cresp.addr_ok;
            n++;
        end
        creq = '0;
        checks++;
        if (!ok || int'(s_count) != DEPTH - 1) begin
            errors++;
            $display("FAIL accept_after_pop: accepted %0b with count %0d expected 1 with %0d",
                     ok, s_count, DEPTH - 1);
        end
        wait_empty();
        checks++;
        if (mem_wr_seen - seen0 != 5) begin
            errors++;
            $display("FAIL full_drain_count: got %0d expected 5", mem_wr_seen - seen0);
        end
    endtask

    task automatic test_read_after_writes();
        int w0 = mem_wr_seen;
        int r0 = mem_rd_seen;
        lat_a_min = 0; lat_a_max = 2; lat_d_min = 0; lat_d_max = 2;
        do_write(32'h8000_0010, 32'h1111_2222, 4'hF, 3'd2);
        do_write(32'h8000_0014, 32'h3333_4444, 4'h3, 3'd1);
        do_read(32'h8000_0010);
        checks++;
        if (s_cresp.data !== s_mresp.data || s_cresp.data_ok !== 1'b1) begin
            errors++;
            $display("FAIL rd_data: got %08h expected %08h", s_cresp.data, s_mresp.data);
        end
        checks++;
        if (mem_wr_seen - w0 != 2 || mem_rd_seen - r0 != 1) begin
            errors++;
            $display("FAIL rd_after_wr: stores %0d loads %0d expected 2 1", mem_wr_seen - w0,
                     mem_rd_seen - r0);
        end
    endtask

    task automatic test_push_pop_wrap();
        int n = 0;
        wait_empty();
        mem_stall = 1;
        lat_a_min = 0; lat_a_max = 0; lat_d_min = 2; lat_d_max = 2;
        for (int i = 0; i < DEPTH - 1; i++)
            do_write(32'h0000_2000 + 32'(i * 4), $urandom, 4'hF, 3'd2);
        mem_stall = 0;
        while (!(mem_phase && mem_dcnt == 0) && n < 50) begin
            tick();
            n++;
        end
        creq        = '0;
        creq.valid  = 1'b1;
        creq.addr   = 32'h0000_2100;
        creq.data   = 32'hCAFE_F00D;
        creq.strobe = 4'hC;
        creq.size   = 3'd1;
        tick();
        checks++;
        if (s_cresp.addr_ok !== 1'b1 || s_mresp.data_ok !== 1'b1 || int'(s_count) != DEPTH - 1) begin
            errors++;
            $display("FAIL pp_accept: ack %0b pop %0b count %0d expected 1 1 %0d",
                     s_cresp.addr_ok, s_mresp.data_ok, s_count, DEPTH - 1);
        end
        creq = '0;
        tick();
        checks++;
        if (int'(s_count) != DEPTH - 1) begin
            errors++;
            $display("FAIL pp_count: got %0d expected %0d", s_count, DEPTH - 1);
        end
        wait_empty();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        lat_a_min = 0; lat_a_max = 0; lat_d_min = 3; lat_d_max = 3;
        creq          = '0;
        creq.valid    = 1'b1;
        creq.addr     = 32'h8000_0040;
        read_addr_exp = 32'h8000_0040;
        while (!read_inflight && n < 50) begin
            tick();
            n++;
        end
        reset = 1'b1;
        creq  = '0;
        tick();
        reset      = 1'b0;
        force_resp = 1;
        tick();
        force_resp = 0;
        checks++;
        if (s_cresp !== '0 || s_mreq.valid !== 1'b0 || s_empty !== 1'b1 || s_count !== '0) begin
            errors++;
            $display("FAIL reset_read: cresp %0b/%0b valid %0b empty %0b count %0d expected 0/0 0 1 0",
                     s_cresp.addr_ok, s_cresp.data_ok, s_mreq.valid, s_empty, s_count);
        end
        mem_stall = 1;
        do_write(32'h0000_3000, $urandom, 4'hF, 3'd2);
        do_write(32'h0000_3004, $urandom, 4'hF, 3'd2);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        mem_stall = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_mreq.valid !== 1'b0 || s_count !== '0 || s_empty !== 1'b1) begin
                errors++;
                $display("FAIL reset_queued: valid %0b count %0d empty %0b expected 0 0 1",
                         s_mreq.valid, s_count, s_empty);
            end
        end
    endtask

    task automatic test_random();
        int w0     = mem_wr_seen;
        int issued = 0;
        lat_a_min = 0; lat_a_max = 3; lat_d_min = 0; lat_d_max = 3;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(99, 0) < 70) begin
                do_write({$urandom_range(255, 0), 2'b00}, $urandom,
                         4'($urandom_range(15, 1)), 3'($urandom_range(2, 0)));
                issued++;
            end else begin
                do_read({$urandom_range(255, 0), 2'b00});
            end
            for (int g = $urandom_range(1, 0); g > 0; g--) tick();
        end
        wait_empty();
        checks++;
        if (mem_wr_seen - w0 != issued) begin
            errors++;
            $display("FAIL random_drained: got %0d stores expected %0d", mem_wr_seen - w0, issued);
        end
    endtask

    initial begin
        reset = 1'b1;
        creq  = '0;
        mresp = '0;
        test_reset();
        test_single_write();
        test_full();
        test_read_after_writes();
        test_push_pop_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
